// File: rtl/mem_resp_stage.sv
// MEM pipeline stage for the data-side sram-like interface: waits for data_ok,
//   buffers the response while WB stalls, extracts lb/lh/lwl/lwr results and
//   forwards to ID. After a flush it counts and discards orphaned responses.
// Latency: zero added cycles when data_ok coincides with the waiting load,
//   otherwise the instruction holds until its response arrives.
// Backpressure: ms_allowin drops while the held instruction cannot leave
//   (no response yet, or WB not accepting).
// Ports: clk/resetn (sync active-low); EXE side es_* plus es_to_ms_valid,
//   es_need_resp, es_orphan; flush; data_sram_data_ok/rdata; WB side
//   ws_allowin, ms_to_ws_valid, ms_to_ws_bus; ID forwarding MEM_dest,
//   MEM_result, MEM_fwd_ok; status ms_cancel_pending, ms_resp_err.
module mem_resp_stage #(
    parameter int PAYLOAD_WD   = 120,
    parameter int CANCEL_DEPTH = 3
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ws_allowin,
    output logic                    ms_allowin,
    input  logic                    es_to_ms_valid,
    input  logic [PAYLOAD_WD-1:0]   es_payload,
    input  logic                    es_gr_we,
    input  logic [4:0]              es_dest,
    input  logic [31:0]             es_alu_result,
    input  logic [31:0]             es_rt_value,
    input  logic                    es_res_from_mem,
    input  logic [5:0]              es_load_op,
    input  logic                    es_need_resp,
    input  logic                    es_orphan,
    input  logic                    flush,
    input  logic                    data_sram_data_ok,
    input  logic [31:0]             data_sram_rdata,
    output logic                    ms_to_ws_valid,
    output logic [PAYLOAD_WD+37:0]  ms_to_ws_bus,
    output logic [4:0]              MEM_dest,
    output logic [31:0]             MEM_result,
    output logic                    MEM_fwd_ok,
    output logic                    ms_cancel_pending,
    output logic                    ms_resp_err
);
    localparam int CNT_W = $clog2(CANCEL_DEPTH + 1);
    localparam int SUM_W = CNT_W + 2;

    // latched instruction state
    logic                   ms_valid;
    logic                   resp_got;
    logic [CNT_W-1:0]       cancel_cnt;
    logic [PAYLOAD_WD-1:0]  payload;
    logic                   gr_we;
    logic [4:0]             dest;
    logic [31:0]            alu_result;
    logic [31:0]            rt_value;
    logic                   res_from_mem;
    logic [5:0]             load_op;
    logic                   need_resp;
    logic [31:0]            resp_buf;

    logic                   wait_resp;
    logic                   cancel_active;
    logic                   take_now;
    logic                   drop_resp;
    logic                   unexpected_resp;
    logic                   ms_ready_go;
    logic [1:0]             flush_inc;
    logic [SUM_W-1:0]       cnt_sum;
    logic [CNT_W-1:0]       cnt_next;
    logic [31:0]            src;
    logic [31:0]            extracted;
    logic [31:0]            final_result;

    assign wait_resp       = ms_valid && need_resp && !resp_got;
    assign cancel_active   = (cancel_cnt != '0);
    // responses are in order: while orphans are outstanding, every data_ok belongs to them
    assign take_now        = data_sram_data_ok && !cancel_active && wait_resp;
    assign drop_resp       = data_sram_data_ok && cancel_active;
    assign unexpected_resp = data_sram_data_ok && !cancel_active && !wait_resp;

    assign ms_ready_go = !need_resp || resp_got || take_now;
    assign ms_allowin  = !ms_valid || (ms_ready_go && ws_allowin);

    // a response consumed in the flush cycle is not owed any more, so it is not counted
    assign flush_inc = flush ? ({1'b0, wait_resp && !take_now} + {1'b0, es_orphan}) : 2'd0;

    always_comb begin
        cnt_sum  = {2'b00, cancel_cnt} + {{(SUM_W-2){1'b0}}, flush_inc}
                 - {{(SUM_W-1){1'b0}}, drop_resp};
        cnt_next = cnt_sum[CNT_W-1:0];
        if (cnt_sum > SUM_W'(CANCEL_DEPTH))
            cnt_next = CNT_W'(CANCEL_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid     <= 1'b0;
            resp_got     <= 1'b0;
            cancel_cnt   <= '0;
            ms_resp_err  <= 1'b0;
            payload      <= '0;
            gr_we        <= 1'b0;
            dest         <= '0;
            alu_result   <= '0;
            rt_value     <= '0;
            res_from_mem <= 1'b0;
            load_op      <= '0;
            need_resp    <= 1'b0;
            resp_buf     <= '0;
        end else begin
            cancel_cnt <= cnt_next;
            if (unexpected_resp)
                ms_resp_err <= 1'b1;

            if (flush)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;

            if (flush)
                resp_got <= 1'b0;
            else if (es_to_ms_valid && ms_allowin)
                resp_got <= 1'b0;
            else if (take_now && !ws_allowin)
                resp_got <= 1'b1;

            // hold the response while WB is stalled
            if (take_now && !ws_allowin)
                resp_buf <= data_sram_rdata;

            if (es_to_ms_valid && ms_allowin) begin
                payload      <= es_payload;
                gr_we        <= es_gr_we;
                dest         <= es_dest;
                alu_result   <= es_alu_result;
                rt_value     <= es_rt_value;
                res_from_mem <= es_res_from_mem;
                load_op      <= es_load_op;
                need_resp    <= es_need_resp;
            end
        end
    end

    // load extraction; load_op = {lwr,lwl,lhu,lh,lbu,lb}, all-zero is lw
    always_comb begin
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        src = take_now ? data_sram_rdata : resp_buf;
        case (alu_result[1:0])
            2'd0:    byte_v = src[7:0];
            2'd1:    byte_v = src[15:8];
            2'd2:    byte_v = src[23:16];
            default: byte_v = src[31:24];
        endcase
        // misaligned halfwords yield zero
        case (alu_result[1:0])
            2'd0:    half_v = src[15:0];
            2'd2:    half_v = src[31:16];
            default: half_v = 16'h0;
        endcase
        extracted = src;
        if (load_op[0])
            extracted = {{24{byte_v[7]}}, byte_v};
        else if (load_op[1])
            extracted = {24'h0, byte_v};
        else if (load_op[2])
            extracted = {{16{half_v[15]}}, half_v};
        else if (load_op[3])
            extracted = {16'h0, half_v};
        else if (load_op[4]) begin
            case (alu_result[1:0])
                2'd0:    extracted = {src[7:0],  rt_value[23:0]};
                2'd1:    extracted = {src[15:0], rt_value[15:0]};
                2'd2:    extracted = {src[23:0], rt_value[7:0]};
                default: extracted = src;
            endcase
        end else if (load_op[5]) begin
            case (alu_result[1:0])
                2'd0:    extracted = src;
                2'd1:    extracted = {rt_value[31:24], src[31:8]};
                2'd2:    extracted = {rt_value[31:16], src[31:16]};
                default: extracted = {rt_value[31:8],  src[31:24]};
            endcase
        end
    end

    assign final_result      = res_from_mem ? extracted : alu_result;
    assign ms_to_ws_valid    = ms_valid && ms_ready_go;
    assign ms_to_ws_bus      = {payload, gr_we, dest, final_result};
    assign MEM_dest          = dest & {5{ms_valid}};
    assign MEM_result        = final_result;
    assign MEM_fwd_ok        = ms_valid && (!res_from_mem || ms_ready_go);
    assign ms_cancel_pending = cancel_active;

endmodule

// File: tb/tb_mem_resp_stage.sv
module tb_mem_resp_stage;
    localparam int PW = 120;
    localparam int BW = PW + 38;

    logic          clk = 1'b0;
    logic          resetn;
    logic          ws_allowin;
    logic          ms_allowin;
    logic          es_to_ms_valid;
    logic [PW-1:0] es_payload;
    logic          es_gr_we;
    logic [4:0]    es_dest;
    logic [31:0]   es_alu_result;
    logic [31:0]   es_rt_value;
    logic          es_res_from_mem;
    logic [5:0]    es_load_op;
    logic          es_need_resp;
    logic          es_orphan;
    logic          flush;
    logic          data_sram_data_ok;
    logic [31:0]   data_sram_rdata;
    logic          ms_to_ws_valid;
    logic [BW-1:0] ms_to_ws_bus;
    logic [4:0]    MEM_dest;
    logic [31:0]   MEM_result;
    logic          MEM_fwd_ok;
    logic          ms_cancel_pending;
    logic          ms_resp_err;

    int tests = 0;
    int fails = 0;
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    mem_resp_stage dut (
        .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_payload(es_payload), .es_gr_we(es_gr_we),
        .es_dest(es_dest), .es_alu_result(es_alu_result), .es_rt_value(es_rt_value),
        .es_res_from_mem(es_res_from_mem), .es_load_op(es_load_op),
        .es_need_resp(es_need_resp), .es_orphan(es_orphan), .flush(flush),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
        .MEM_dest(MEM_dest), .MEM_result(MEM_result), .MEM_fwd_ok(MEM_fwd_ok),
        .ms_cancel_pending(ms_cancel_pending), .ms_resp_err(ms_resp_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // monitor: every WB handoff must match the oldest expected entry
    initial begin
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && ms_to_ws_valid === 1'b1 && ws_allowin === 1'b1 && flush === 1'b0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_wb: got bus result 0x%08h with no expected entry",
                             ms_to_ws_bus[31:0]);
                end else begin
                    logic [BW-1:0] e;
                    e = exp_q.pop_front();
                    if (ms_to_ws_bus !== e) begin
                        fails++;
                        $display("FAIL wb_bus: got dest %0d result 0x%08h pl 0x%08h, expected dest %0d result 0x%08h pl 0x%08h",
                                 ms_to_ws_bus[36:32], ms_to_ws_bus[31:0], ms_to_ws_bus[69:38],
                                 e[36:32], e[31:0], e[69:38]);
                    end
                end
            end
        end
    end

    // present one instruction to MEM and hold it for one accepting edge
    task automatic issue(input logic [4:0] d, input logic [31:0] addr, input logic [31:0] rt,
                         input logic mem, input logic [5:0] op, input logic need,
                         input logic push, input logic [31:0] exp_res);
        logic [PW-1:0] pl;
        pl = {24'hABCDEF, 64'h0, addr};
        es_payload      = pl;
        es_gr_we        = 1'b1;
        es_dest         = d;
        es_alu_result   = addr;
        es_rt_value     = rt;
        es_res_from_mem = mem;
        es_load_op      = op;
        es_need_resp    = need;
        es_to_ms_valid  = 1'b1;
        @(negedge clk);
        check("issue_allowin", {31'h0, ms_allowin}, 32'h1);
        if (push) exp_q.push_back({pl, 1'b1, d, exp_res});
        @(posedge clk); #1;
        es_to_ms_valid = 1'b0;
    endtask

    // load whose response arrives the cycle after acceptance
    task automatic do_load(input logic [4:0] d, input logic [31:0] addr, input logic [31:0] rt,
                           input logic [5:0] op, input logic [31:0] rd, input logic [31:0] exp_res);
        issue(d, addr, rt, 1'b1, op, 1'b1, 1'b1, exp_res);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        @(posedge clk); #1;
        data_sram_data_ok = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_payload = '0;
        es_gr_we = 1'b0; es_dest = '0; es_alu_result = '0; es_rt_value = '0;
        es_res_from_mem = 1'b0; es_load_op = '0; es_need_resp = 1'b0; es_orphan = 1'b0;
        flush = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // reset state
        @(negedge clk);
        check("rst_to_ws_valid", {31'h0, ms_to_ws_valid}, 32'h0);
        check("rst_allowin", {31'h0, ms_allowin}, 32'h1);
        check("rst_mem_dest", {27'h0, MEM_dest}, 32'h0);
        check("rst_cancel_pending", {31'h0, ms_cancel_pending}, 32'h0);
        check("rst_resp_err", {31'h0, ms_resp_err}, 32'h0);
        @(posedge clk); #1;

        // lw, data_ok on the third cycle after accept
        issue(5'd5, 32'h100, 32'h0, 1'b1, 6'b0, 1'b1, 1'b1, 32'hDEADBEEF);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lw_wait_fwd_ok", {31'h0, MEM_fwd_ok}, 32'h0);
            check("lw_wait_valid", {31'h0, ms_to_ws_valid}, 32'h0);
            check("lw_wait_allowin", {31'h0, ms_allowin}, 32'h0);
            @(posedge clk); #1;
        end
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("lw_valid_same_cycle", {31'h0, ms_to_ws_valid}, 32'h1);
        check("lw_fwd_ok", {31'h0, MEM_fwd_ok}, 32'h1);
        check("lw_mem_result", MEM_result, 32'hDEADBEEF);
        check("lw_mem_dest", {27'h0, MEM_dest}, 32'd5);
        @(posedge clk); #1;
        data_sram_data_ok = 1'b0;

        // lb a=3 with WB stalled: result must come from the buffer
        issue(5'd6, 32'h203, 32'h0, 1'b1, 6'b000001, 1'b1, 1'b1, 32'hFFFFFF80);
        ws_allowin = 1'b0; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF0011;
        @(negedge clk);
        check("lb_stall_allowin", {31'h0, ms_allowin}, 32'h0);
        @(posedge clk); #1;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("lb_held_allowin", {31'h0, ms_allowin}, 32'h0);
            check("lb_held_result", MEM_result, 32'hFFFFFF80);
            @(posedge clk); #1;
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        check("lb_release_allowin", {31'h0, ms_allowin}, 32'h1);
        @(posedge clk); #1;

        // extraction vectors
        do_load(5'd7,  32'h301, 32'h11223344, 6'b010000, 32'hAABBCCDD, 32'hCCDD3344); // lwl a=1
        do_load(5'd8,  32'h302, 32'h11223344, 6'b100000, 32'hAABBCCDD, 32'h1122AABB); // lwr a=2
        do_load(5'd13, 32'h303, 32'h11223344, 6'b010000, 32'hAABBCCDD, 32'hAABBCCDD); // lwl a=3
        do_load(5'd14, 32'h301, 32'h11223344, 6'b100000, 32'hAABBCCDD, 32'h11AABBCC); // lwr a=1
        do_load(5'd15, 32'h302, 32'h0,        6'b000100, 32'h80010000, 32'hFFFF8001); // lh a=2
        do_load(5'd16, 32'h300, 32'h0,        6'b001000, 32'h12348765, 32'h00008765); // lhu a=0
        do_load(5'd17, 32'h301, 32'h0,        6'b000100, 32'h12348765, 32'h00000000); // lh a=1
        do_load(5'd18, 32'h301, 32'h0,        6'b000010, 32'h1234ABCD, 32'h000000AB); // lbu a=1

        // non-memory instruction passes straight through
        issue(5'd12, 32'hCAFEF00D, 32'h0, 1'b0, 6'b0, 1'b0, 1'b1, 32'hCAFEF00D);
        @(negedge clk);
        check("alu_fwd_ok", {31'h0, MEM_fwd_ok}, 32'h1);
        check("alu_mem_dest", {27'h0, MEM_dest}, 32'd12);
        @(posedge clk); #1;

        // flush while waiting plus an orphan in EXE: two responses dropped
        issue(5'd9, 32'h400, 32'h0, 1'b1, 6'b0, 1'b1, 1'b0, 32'h0);
        flush = 1'b1; es_orphan = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; es_orphan = 1'b0;
        @(negedge clk);
        check("flush_cancel_pending", {31'h0, ms_cancel_pending}, 32'h1);
        check("flush_mem_dest", {27'h0, MEM_dest}, 32'h0);
        @(posedge clk); #1;
        issue(5'd10, 32'h404, 32'h0, 1'b1, 6'b0, 1'b1, 1'b1, 32'h33333333);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h11111111;
        @(negedge clk);
        check("drop1_valid", {31'h0, ms_to_ws_valid}, 32'h0);
        check("drop1_pending", {31'h0, ms_cancel_pending}, 32'h1);
        @(posedge clk); #1;
        data_sram_rdata = 32'h22222222;
        @(negedge clk);
        check("drop2_valid", {31'h0, ms_to_ws_valid}, 32'h0);
        check("drop2_pending", {31'h0, ms_cancel_pending}, 32'h1);
        @(posedge clk); #1;
        data_sram_rdata = 32'h33333333;
        @(negedge clk);
        check("third_valid", {31'h0, ms_to_ws_valid}, 32'h1);
        check("third_pending", {31'h0, ms_cancel_pending}, 32'h0);
        @(posedge clk); #1;
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("cancel_no_err", {31'h0, ms_resp_err}, 32'h0);
        @(posedge clk); #1;

        // flush coinciding with the response: consumed, nothing counted
        issue(5'd11, 32'h500, 32'h0, 1'b1, 6'b0, 1'b1, 1'b0, 32'h0);
        flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h55555555;
        @(posedge clk); #1;
        flush = 1'b0; data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("flush_ok_pending", {31'h0, ms_cancel_pending}, 32'h0);
        check("flush_ok_valid", {31'h0, ms_to_ws_valid}, 32'h0);
        check("flush_ok_err", {31'h0, ms_resp_err}, 32'h0);
        check("flush_ok_allowin", {31'h0, ms_allowin}, 32'h1);
        @(posedge clk); #1;

        // unexpected response sets the sticky error; reset clears it
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h77777777;
        @(posedge clk); #1;
        data_sram_data_ok = 1'b0;
        @(negedge clk);
        check("unexp_err_set", {31'h0, ms_resp_err}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        check("unexp_err_sticky", {31'h0, ms_resp_err}, 32'h1);
        @(posedge clk); #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("reset_clears_err", {31'h0, ms_resp_err}, 32'h0);
        check("reset_allowin", {31'h0, ms_allowin}, 32'h1);

        check("queue_drained", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_resp_stage.md
Name: mem_resp_stage

Overview:
- Next-generation MEM pipeline stage for the data-side sram-like interface. Data returns one or more cycles after the request via data_sram_data_ok, so the stage waits for it instead of assuming a fixed 1-cycle SRAM.
- Buffers the response while WB is stalled.
- Performs load byte/half/lwl/lwr extraction.
- After a flush, counts and discards orphaned responses from cancelled requests.
- Sits between EXE (which issues the request) and WB; forwards its result to ID.

Parameters:
- PAYLOAD_WD, 120: width of the opaque sideband (pc, exception, cp0, tlb fields) passed through unchanged.
- CANCEL_DEPTH, 3: maximum number of orphaned responses the cancel counter can hold. The counter width is clog2(CANCEL_DEPTH+1).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- ws_allowin  in  1  WB can accept
- ms_allowin  out  1  MEM can accept
- es_to_ms_valid  in  1  EXE has an instruction
- es_payload  in  PAYLOAD_WD  sideband
- es_gr_we  in  1  RF write enable
- es_dest  in  5  RF write address
- es_alu_result  in  32  ALU result / memory address
- es_rt_value  in  32  rt, used for lwl/lwr merge
- es_res_from_mem  in  1  load
- es_load_op  in  6  one-hot {lwr,lwl,lhu,lh,lbu,lb}; all-zero means lw
- es_need_resp  in  1  EXE's request was accepted (addr_ok seen); a data_ok is owed
- es_orphan  in  1  on flush, EXE holds an accepted request that is being squashed
- flush  in  1  exception/eret/refill flush
- data_sram_data_ok  in  1  response strobe; responses return in order
- data_sram_rdata  in  32  response data
- ms_to_ws_valid  out  1
- ms_to_ws_bus  out  PAYLOAD_WD+38  {payload, gr_we, dest[4:0], final_result[31:0]}
- MEM_dest  out  5  dest gated by ms_valid
- MEM_result  out  32  final result
- MEM_fwd_ok  out  1  MEM_result is valid for forwarding
- ms_cancel_pending  out  1  cancel counter nonzero
- ms_resp_err  out  1  sticky; set by an unexpected data_ok

Behaviour:
- Reset (resetn=0 at clk edge):
  - ms_valid=0, resp_got=0, cancel_cnt=0, ms_resp_err=0, all latched fields 0.
  - Outputs follow: ms_to_ws_valid=0, ms_allowin=1, MEM_dest=0, ms_cancel_pending=0.
- Acceptance:
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - On ms_allowin, ms_valid <= es_to_ms_valid.
  - On es_to_ms_valid && ms_allowin, latch all es_* fields and clear resp_got.
- Waiting for data:
  - take_now = data_sram_data_ok && cancel_cnt==0 && ms_valid && need_resp && !resp_got.
  - ms_ready_go = !need_resp || resp_got || take_now. Same-cycle bypass: zero added latency when data_ok coincides.
  - When take_now and !ws_allowin: resp_buf <= rdata, resp_got <= 1.
  - Extraction source is take_now ? data_sram_rdata : resp_buf.
- Cancel counter (CANCEL state is cancel_cnt>0):
  - data_ok with cancel_cnt>0: decrement; data is discarded and never reaches the instruction.
  - On flush, inc = (ms_valid && need_resp && !resp_got && !take_now) + es_orphan, range 0..2.
  - Update: cancel_cnt <= cancel_cnt + inc − (data_ok && cancel_cnt>0).
  - Saturate at CANCEL_DEPTH. EXE must not issue while ms_cancel_pending is set and the count is at depth; overflow is not required behaviour.
- Flush:
  - ms_valid <= 0 and resp_got <= 0, with priority over acceptance.
  - flush in the same cycle as take_now: the response is consumed (not counted), and the instruction is squashed.
- Unexpected data_ok (cancel_cnt==0 and no waiting instruction): ignored; ms_resp_err <= 1, cleared only by reset.
- Load extraction; a = alu_result[1:0], d = data source:
  - lb/lbu: byte a, sign/zero-extended.
  - lh/lhu: half at a∈{0,2}; a∈{1,3} gives 0.
  - lwl: a=0 gives {d[7:0],rt[23:0]}; a=1 {d[15:0],rt[15:0]}; a=2 {d[23:0],rt[7:0]}; a=3 d.
  - lwr: a=0 gives d; a=1 {rt[31:24],d[31:8]}; a=2 {rt[31:16],d[31:16]}; a=3 {rt[31:8],d[31:24]}.
  - lw: d.
- Final result and forwarding:
  - final_result = res_from_mem ? extracted : alu_result.
  - MEM_dest = dest & {5{ms_valid}}; MEM_result = final_result.
  - MEM_fwd_ok = ms_valid && (!res_from_mem || ms_ready_go).
  - ms_to_ws_valid = ms_valid && ms_ready_go.

Test Plan:
- Load lw at addr 0x100, data_ok with rdata=0xDEADBEEF 3 cycles after accept, ws_allowin=1 → ms_to_ws_valid rises the same cycle as data_ok; result 0xDEADBEEF; MEM_fwd_ok=0 for the 2 preceding cycles.
- lb at a=3, rdata=0x80FF0011, ws_allowin=0 when data_ok arrives, released 2 cycles later → result 0xFFFFFF80 from the buffer; ms_allowin=0 until release.
- lwl a=1, rt=0x11223344, rdata=0xAABBCCDD → 0xCCDD3344. lwr a=2 with the same inputs → 0x1122AABB.
- flush while MEM waits and es_orphan=1 → cancel_cnt=2. The next two data_ok are dropped (ms_to_ws_valid stays 0). A new load accepted afterwards receives the third data_ok.
- flush in the same cycle as data_ok for the waiting load → cancel_cnt stays 0, no WB valid.
- data_ok with an empty stage and cancel_cnt=0 → ms_resp_err=1. resetn=0 clears it and leaves ms_allowin=1.
